// File: rtl/bp_checkpoint_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : bp_checkpoint_ctrl
// Brief   : In-order checkpoint queue for gshare predictions; issues counter
//           updates and GHR restore/flush on mispredict.
//           Optional statistics counters built when BP_CKPT_STATS_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module bp_checkpoint_ctrl #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 9,
    parameter int GHR_W = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pred_valid,
    output logic                       pred_ready,
    input  logic [IDX_W-1:0]           pred_idx,
    input  logic [GHR_W-1:0]           pred_ghr,
    input  logic                       pred_taken,
    input  logic                       res_valid,
    input  logic                       res_taken,
    output logic                       upd_valid,
    output logic [IDX_W-1:0]           upd_idx,
    output logic                       upd_inc,
    output logic                       ghr_restore_valid,
    output logic [GHR_W-1:0]           ghr_restore_val,
    output logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       res_err,
    output logic [31:0]                stat_resolved,
    output logic [31:0]                stat_mispred
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;

    typedef enum logic [0:0] {
        NORMAL  = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t             r_state;
    logic [c_PW-1:0]    r_head;
    logic [c_PW-1:0]    r_tail;
    logic [IDX_W-1:0]   r_idx [DEPTH];
    logic [GHR_W-1:0]   r_ghr [DEPTH];
    logic               r_tkn [DEPTH];

    logic               w_nonempty;
    logic               w_pop;
    logic               w_mispred;
    logic               w_push;
    logic               w_res_empty;
    logic [GHR_W-1:0]   w_snap;
    logic               w_unused_snap_msb;

    assign w_nonempty  = (count != '0);
    assign w_pop       = (r_state == NORMAL) && res_valid && w_nonempty;
    assign w_mispred   = w_pop && (res_taken != r_tkn[r_head]);
    assign w_res_empty = (r_state == NORMAL) && res_valid && !w_nonempty;
    assign pred_ready  = (r_state == NORMAL) && !w_mispred &&
                         ((count < c_CW'(DEPTH)) || w_pop);
    assign w_push      = pred_valid && pred_ready;
    assign w_snap      = r_ghr[r_head];
    // History MSB falls off the shift when the corrected direction is appended.
    assign w_unused_snap_msb = w_snap[GHR_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= NORMAL;
            r_head            <= '0;
            r_tail            <= '0;
            count             <= '0;
            upd_valid         <= 1'b0;
            upd_idx           <= '0;
            upd_inc           <= 1'b0;
            ghr_restore_valid <= 1'b0;
            ghr_restore_val   <= '0;
            flush             <= 1'b0;
            res_err           <= 1'b0;
        end else begin
            upd_valid         <= 1'b0;
            ghr_restore_valid <= 1'b0;
            flush             <= 1'b0;
            if (r_state == RECOVER)
                r_state <= NORMAL;
            if (w_push) begin
                r_idx[r_tail] <= pred_idx;
                r_ghr[r_tail] <= pred_ghr;
                r_tkn[r_tail] <= pred_taken;
            end
            if (w_pop) begin
                upd_valid <= 1'b1;
                upd_idx   <= r_idx[r_head];
                upd_inc   <= res_taken;
            end
            if (w_mispred) begin
                // Queue is dropped in full; younger entries belong to the wrong path.
                r_state           <= RECOVER;
                ghr_restore_valid <= 1'b1;
                ghr_restore_val   <= {w_snap[GHR_W-2:0], res_taken};
                flush             <= 1'b1;
                count             <= '0;
                r_head            <= r_tail;
            end else begin
                if (w_push)
                    r_tail <= r_tail + c_PW'(1);
                if (w_pop)
                    r_head <= r_head + c_PW'(1);
                if (w_push && !w_pop)
                    count <= count + c_CW'(1);
                else if (!w_push && w_pop)
                    count <= count - c_CW'(1);
            end
            if (w_res_empty)
                res_err <= 1'b1;
        end
    end

`ifdef BP_CKPT_STATS_EN
    logic [31:0] r_stat_resolved;
    logic [31:0] r_stat_mispred;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_resolved <= '0;
            r_stat_mispred  <= '0;
        end else begin
            if (w_pop)
                r_stat_resolved <= r_stat_resolved + 32'd1;
            if (w_mispred)
                r_stat_mispred  <= r_stat_mispred + 32'd1;
        end
    end

    assign stat_resolved = r_stat_resolved;
    assign stat_mispred  = r_stat_mispred;
`else
    assign stat_resolved = '0;
    assign stat_mispred  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_checkpoint_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_bp_checkpoint_ctrl
// Brief   : Directed self-checking bench for bp_checkpoint_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bp_checkpoint_ctrl;

    localparam int DEPTH = 4;
    localparam int IDX_W = 9;
    localparam int GHR_W = 9;

    logic             clk = 1'b0;
    logic             rst;
    logic             pred_valid;
    logic             pred_ready;
    logic [IDX_W-1:0] pred_idx;
    logic [GHR_W-1:0] pred_ghr;
    logic             pred_taken;
    logic             res_valid;
    logic             res_taken;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_inc;
    logic             ghr_restore_valid;
    logic [GHR_W-1:0] ghr_restore_val;
    logic             flush;
    logic [2:0]       count;
    logic             res_err;
    logic [31:0]      stat_resolved;
    logic [31:0]      stat_mispred;

    int n_checks = 0;
    int n_pass   = 0;

    bp_checkpoint_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W), .GHR_W(GHR_W)) u_dut (
        .clk               (clk),
        .rst               (rst),
        .pred_valid        (pred_valid),
        .pred_ready        (pred_ready),
        .pred_idx          (pred_idx),
        .pred_ghr          (pred_ghr),
        .pred_taken        (pred_taken),
        .res_valid         (res_valid),
        .res_taken         (res_taken),
        .upd_valid         (upd_valid),
        .upd_idx           (upd_idx),
        .upd_inc           (upd_inc),
        .ghr_restore_valid (ghr_restore_valid),
        .ghr_restore_val   (ghr_restore_val),
        .flush             (flush),
        .count             (count),
        .res_err           (res_err),
        .stat_resolved     (stat_resolved),
        .stat_mispred      (stat_mispred)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [IDX_W-1:0] idx, input logic [GHR_W-1:0] ghr, input logic tkn);
        pred_valid = 1'b1;
        pred_idx   = idx;
        pred_ghr   = ghr;
        pred_taken = tkn;
        step();
        pred_valid = 1'b0;
    endtask

    task automatic resolve(input logic tkn);
        res_valid = 1'b1;
        res_taken = tkn;
        step();
        res_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pred_valid = 1'b0; pred_idx = '0; pred_ghr = '0;
        pred_taken = 1'b0; res_valid = 1'b0; res_taken = 1'b0;
        step(); step();
        rst = 1'b0;
        step();

        check("rst_count",  32'(count), 0);
        check("rst_ready",  32'(pred_ready), 1);
        check("rst_upd",    32'(upd_valid), 0);
        check("rst_flush",  32'(flush), 0);
        check("rst_restore", 32'(ghr_restore_valid), 0);
        check("rst_err",    32'(res_err), 0);
        check("rst_stat_r", stat_resolved, 0);

        // Fill the queue, then a fifth prediction must stall.
        for (int i = 0; i < 4; i++)
            push(9'h010 + 9'(i), 9'h100 + 9'(i), 1'b1);
        pred_valid = 1'b1; pred_idx = 9'h014; pred_ghr = 9'h104; pred_taken = 1'b1;
        #1;
        check("full_ready", 32'(pred_ready), 0);
        check("full_count", 32'(count), 4);

        // Push and correct resolve in the same cycle on a full queue.
        res_valid = 1'b1; res_taken = 1'b1;
        #1;
        check("pp_ready", 32'(pred_ready), 1);
        step();
        pred_valid = 1'b0; res_valid = 1'b0;
        check("pp_count",   32'(count), 4);
        check("pp_upd_v",   32'(upd_valid), 1);
        check("pp_upd_idx", 32'(upd_idx), 32'h010);
        check("pp_upd_inc", 32'(upd_inc), 1);

        for (int i = 1; i < 5; i++) begin
            resolve(1'b1);
            check("drain_idx", 32'(upd_idx), 32'h010 + 32'(i));
        end
        check("drain_count", 32'(count), 0);
        step();
        check("upd_pulse", 32'(upd_valid), 0);

        // Mispredict with two younger entries queued.
        push(9'h020, 9'h0A5, 1'b1);
        push(9'h021, 9'h14B, 1'b0);
        push(9'h022, 9'h096, 1'b1);
        res_valid = 1'b1; res_taken = 1'b0;
        #1;
        check("mp_ready_n", 32'(pred_ready), 0);
        step();
        res_valid = 1'b0;
        check("mp_restore_v", 32'(ghr_restore_valid), 1);
        check("mp_restore",   32'(ghr_restore_val), 32'h14A);
        check("mp_flush",     32'(flush), 1);
        check("mp_upd_v",     32'(upd_valid), 1);
        check("mp_upd_idx",   32'(upd_idx), 32'h020);
        check("mp_upd_inc",   32'(upd_inc), 0);
        check("mp_count",     32'(count), 0);
        check("mp_ready_rc",  32'(pred_ready), 0);
        step();
        check("mp_ready_after", 32'(pred_ready), 1);
        check("mp_flush_pulse", 32'(flush), 0);
        check("mp_restore_pulse", 32'(ghr_restore_valid), 0);

        // Mispredict coinciding with a push; RECOVER ignores both inputs.
        push(9'h030, 9'h001, 1'b0);
        pred_valid = 1'b1; pred_idx = 9'h031; pred_ghr = 9'h002; pred_taken = 1'b1;
        res_valid = 1'b1; res_taken = 1'b1;
        step();
        check("mp2_count_rc", 32'(count), 0);
        check("mp2_ready_rc", 32'(pred_ready), 0);
        check("mp2_restore",  32'(ghr_restore_val), 32'h003);
        step();
        pred_valid = 1'b0; res_valid = 1'b0;
        check("mp2_count",  32'(count), 0);
        check("mp2_err",    32'(res_err), 0);
        check("mp2_upd_v",  32'(upd_valid), 0);

        // Remaining resolves for a 10-resolve / 3-mispredict tally.
        push(9'h040, 9'h010, 1'b1);
        push(9'h041, 9'h021, 1'b1);
        resolve(1'b1);
        check("st_upd_idx", 32'(upd_idx), 32'h040);
        resolve(1'b0);
        check("st_restore", 32'(ghr_restore_val), 32'h042);
        step();
        push(9'h050, 9'h033, 1'b1);
        resolve(1'b1);
        check("st_upd_idx2", 32'(upd_idx), 32'h050);
`ifdef BP_CKPT_STATS_EN
        check("stat_resolved", stat_resolved, 10);
        check("stat_mispred",  stat_mispred, 3);
`else
        check("stat_resolved", stat_resolved, 0);
        check("stat_mispred",  stat_mispred, 0);
`endif

        // Resolve on an empty queue.
        resolve(1'b1);
        check("empty_upd_v", 32'(upd_valid), 0);
        check("empty_err",   32'(res_err), 1);
        check("empty_count", 32'(count), 0);
        step(); step();
        check("err_sticky",  32'(res_err), 1);

        // Reset arriving during RECOVER.
        push(9'h060, 9'h0FF, 1'b1);
        resolve(1'b0);
        check("rr_flush", 32'(flush), 1);
        rst = 1'b1;
        step();
        check("rr_flush_clr",   32'(flush), 0);
        check("rr_restore_clr", 32'(ghr_restore_valid), 0);
        check("rr_upd_clr",     32'(upd_valid), 0);
        check("rr_err_clr",     32'(res_err), 0);
        check("rr_ready",       32'(pred_ready), 1);
        check("rr_stat",        stat_mispred, 0);
        rst = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
